// File: rtl/nn_stream_pkg.sv
// Shared types and sizing helpers for the result streaming path.
package nn_stream_pkg;

  typedef enum logic {IDLE, SEND} tx_state_t;

  localparam int DEF_NUM_ELEM = 10;

  function automatic int beats_per_frame(input int num_elem, input int append_class);
    return num_elem + ((append_class != 0) ? 1 : 0);
  endfunction

  // Room for the class beat plus one spare code, so the counter never aliases.
  function automatic int beat_cnt_w(input int num_elem);
    return $clog2(num_elem + 2);
  endfunction

  localparam int BEAT_CNT_W = $clog2(DEF_NUM_ELEM + 2);

endpackage

// File: rtl/axis_result_tx_vec_slot.sv
// One-deep holding register for a vector plus its class index.
module vec_slot #(
  parameter int W = 176
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         take,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;

  // A take and a load in the same cycle leave the slot full with the new entry.
  always_comb begin
    data_d = load ? din : data_q;
    full_d = load | (full_q & ~take);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/axis_result_tx.sv
// AXI-Stream master that serialises the final-layer output vector, optionally
// followed by the class index, with a one-deep pending slot for back-to-back inferences.
module axis_result_tx
  import nn_stream_pkg::*;
#(
  parameter int NUM_ELEM     = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int APPEND_CLASS = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vec_valid,
  input  logic [NUM_ELEM*DATA_WIDTH-1:0] vec_data,
  input  logic [DATA_WIDTH-1:0]          class_idx,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           busy,
  output logic                           overflow,
  input  logic                           clr_overflow,
  output logic [CNT_WIDTH-1:0]           frame_cnt,
  output logic [CNT_WIDTH-1:0]           drop_cnt
);

  localparam int BEATS = beats_per_frame(NUM_ELEM, APPEND_CLASS);
  localparam int BCW   = beat_cnt_w(NUM_ELEM);
  localparam int FRM_W = (NUM_ELEM + 1) * DATA_WIDTH;
  localparam logic [BCW-1:0]       LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  tx_state_t            state_q, state_d;
  logic [FRM_W-1:0]     sreg_q, sreg_d;
  logic [BCW-1:0]       beat_q, beat_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 busy_q, busy_d;

  logic             slot_load, slot_take, slot_full, drop, hs, fin;
  logic [FRM_W-1:0] slot_dout, in_frm;

  // Class index rides on top so it reaches the low lane after the last element.
  assign in_frm = {class_idx, vec_data};

  vec_slot #(.W(FRM_W)) u_pend (
    .clk  (clk),
    .rst  (rst),
    .load (slot_load),
    .take (slot_take),
    .din  (in_frm),
    .dout (slot_dout),
    .full (slot_full)
  );

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tdata  = sreg_q[DATA_WIDTH-1:0];
  assign m_axis_tlast  = m_axis_tvalid & (beat_q == LAST_BEAT);
  assign hs  = m_axis_tvalid & m_axis_tready;
  assign fin = hs & (beat_q == LAST_BEAT);

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    beat_d      = beat_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q;
    slot_load   = 1'b0;
    slot_take   = 1'b0;
    drop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (vec_valid) begin
          sreg_d  = in_frm;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (fin) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          beat_d      = '0;
          if (slot_full) begin
            sreg_d    = slot_dout;
            slot_take = 1'b1;
          end else if (vec_valid) begin
            sreg_d = in_frm;
          end else begin
            state_d = IDLE;
          end
        end else if (hs) begin
          sreg_d = sreg_q >> DATA_WIDTH;
          beat_d = beat_q + 1'b1;
        end
        // On a final beat with the slot full, the slot drains this cycle and can take the new vector.
        if (vec_valid && !(fin && !slot_full)) begin
          if (slot_full && !fin) drop = 1'b1;
          else                   slot_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (clr_overflow)             drop_cnt_d = CNT_WIDTH'(1);
      else if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end

    busy_d = (state_d == SEND) | slot_load | (slot_full & ~slot_take);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      beat_q      <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      beat_q      <= beat_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_axis_result_tx.sv
// Scoreboard bench: stimulus pushes expected beats, negedge monitors pop and compare.
module tb_axis_result_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        vec_valid, tready, clr_overflow;
  logic [63:0] vec_data;
  logic [15:0] class_idx, tdata, frame_cnt, drop_cnt;
  logic        tvalid, tlast, busy, overflow;

  logic        vec_valid2, tready2, clr_overflow2;
  logic [15:0] vec_data2, class_idx2, tdata2, frame_cnt2, drop_cnt2;
  logic        tvalid2, tlast2, busy2, overflow2;

  axis_result_tx #(.NUM_ELEM(4), .DATA_WIDTH(16), .APPEND_CLASS(1), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .vec_valid(vec_valid), .vec_data(vec_data), .class_idx(class_idx),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
    .busy(busy), .overflow(overflow), .clr_overflow(clr_overflow),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  axis_result_tx #(.NUM_ELEM(1), .DATA_WIDTH(16), .APPEND_CLASS(0), .CNT_WIDTH(16)) dut2 (
    .clk(clk), .rst(rst), .vec_valid(vec_valid2), .vec_data(vec_data2), .class_idx(class_idx2),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(tready2), .m_axis_tlast(tlast2),
    .busy(busy2), .overflow(overflow2), .clr_overflow(clr_overflow2),
    .frame_cnt(frame_cnt2), .drop_cnt(drop_cnt2)
  );

  typedef struct packed { logic [15:0] d; logic l; } beat_t;
  beat_t q1[$], q2[$];
  beat_t b1, b2;
  int total = 0, bad = 0, hs_cnt = 0, exp_frames = 0, h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] e0, e1, e2, e3, c, input bit exp, input bit clr);
    vec_valid    = 1'b1;
    vec_data     = {e3, e2, e1, e0};
    class_idx    = c;
    clr_overflow = clr;
    if (exp) begin
      q1.push_back('{e0, 1'b0}); q1.push_back('{e1, 1'b0});
      q1.push_back('{e2, 1'b0}); q1.push_back('{e3, 1'b0});
      q1.push_back('{c, 1'b1});
      exp_frames++;
    end
    tick;
    vec_valid    = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    tready = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      if (q1.size() == 0 && !tvalid) return;
      tick;
    end
    chk("drain_timeout", 0, 1);
  endtask

  // Monitor for the 4-element DUT, including the AXIS hold-while-stalled rule.
  logic        stall = 1'b0, sl;
  logic [15:0] sd;
  always @(negedge clk) begin
    if (rst) stall = 1'b0;
    else begin
      if (stall) begin
        chk("hold_valid", {31'd0, tvalid}, 1);
        chk("hold_data", {16'd0, tdata}, {16'd0, sd});
        chk("hold_last", {31'd0, tlast}, {31'd0, sl});
      end
      if (tvalid && tready) begin
        hs_cnt++;
        if (q1.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          b1 = q1.pop_front();
          chk("beat_data", {16'd0, tdata}, {16'd0, b1.d});
          chk("beat_last", {31'd0, tlast}, {31'd0, b1.l});
        end
      end
      stall = tvalid && !tready;
      sd = tdata;
      sl = tlast;
    end
  end

  always @(negedge clk) begin
    if (!rst && tvalid2 && tready2) begin
      if (q2.size() == 0) chk("unexpected_beat2", 1, 0);
      else begin
        b2 = q2.pop_front();
        chk("beat2_data", {16'd0, tdata2}, {16'd0, b2.d});
        chk("beat2_last", {31'd0, tlast2}, {31'd0, b2.l});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vec_valid = 0; tready = 0; clr_overflow = 0; vec_data = '0; class_idx = '0;
    vec_valid2 = 0; tready2 = 0; clr_overflow2 = 0; vec_data2 = '0; class_idx2 = '0;
    #2;
    chk("rst_tvalid", {31'd0, tvalid}, 0);
    chk("rst_tlast", {31'd0, tlast}, 0);
    chk("rst_tdata", {16'd0, tdata}, 0);
    chk("rst_status", {28'd0, busy, overflow, busy2, overflow2}, 0);
    chk("rst_cnts", {frame_cnt, drop_cnt}, 0);
    chk("rst_cnts2", {frame_cnt2, drop_cnt2}, 0);
    #10 rst = 1'b0;
    tick;

    // 1: basic frame, latency 1, class beat last
    tready = 1'b1;
    pulse(16'd1, 16'd2, 16'd3, 16'd4, 16'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_tvalid", {31'd0, tvalid}, 1);
    chk("lat_tdata", {16'd0, tdata}, 1);
    chk("lat_busy", {31'd0, busy}, 1);
    wait_idle(40);
    tick;
    chk("t1_frame_cnt", {16'd0, frame_cnt}, exp_frames);
    chk("t1_busy", {31'd0, busy}, 0);

    // 2: backpressure pattern 1,0,0,1
    pulse(16'd1, 16'd2, 16'd3, 16'd4, 16'd2, 1'b1, 1'b0);
    h0 = hs_cnt;
    for (int i = 0; i < 40; i++) begin
      if (q1.size() == 0 && !tvalid) break;
      tready = (i % 4 == 0) || (i % 4 == 3);
      tick;
    end
    chk("t2_handshakes", hs_cnt - h0, 5);
    chk("t2_q_empty", q1.size(), 0);
    wait_idle(40);
    chk("t2_frame_cnt", {16'd0, frame_cnt}, exp_frames);

    // 3: back-to-back frames, third vector on the final-beat cycle
    tready = 1'b1;
    pulse(16'd1, 16'd2, 16'd3, 16'd4, 16'd2, 1'b1, 1'b0);
    fork
      begin
        repeat (15) begin
          @(negedge clk);
          chk("t3_no_bubble", {31'd0, tvalid}, 1);
        end
        @(negedge clk);
        chk("t3_end_idle", {31'd0, tvalid}, 0);
      end
      begin
        tick;
        pulse(16'd5, 16'd6, 16'd7, 16'd8, 16'd3, 1'b1, 1'b0);
        tick;
        tick;
        pulse(16'h9, 16'hA, 16'hB, 16'hC, 16'd1, 1'b1, 1'b0);
      end
    join
    wait_idle(40);
    chk("t3_frame_cnt", {16'd0, frame_cnt}, exp_frames);

    // 4: stalled sink, one stored, one dropped
    tready = 1'b0;
    pulse(16'h11, 16'h12, 16'h13, 16'h14, 16'd0, 1'b1, 1'b0);
    pulse(16'h21, 16'h22, 16'h23, 16'h24, 16'd1, 1'b1, 1'b0);
    pulse(16'h31, 16'h32, 16'h33, 16'h34, 16'd2, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_overflow", {31'd0, overflow}, 1);
    chk("t4_drop_cnt", {16'd0, drop_cnt}, 1);
    chk("t4_busy", {31'd0, busy}, 1);
    wait_idle(60);
    chk("t4_frame_cnt", {16'd0, frame_cnt}, exp_frames);
    clr_overflow = 1'b1;
    tick;
    clr_overflow = 1'b0;
    chk("t4_clr_overflow", {31'd0, overflow}, 0);
    chk("t4_clr_drop_cnt", {16'd0, drop_cnt}, 0);

    // 4b: clear coinciding with a drop -> drop wins, count restarts at 1
    tready = 1'b0;
    pulse(16'h41, 16'h42, 16'h43, 16'h44, 16'd0, 1'b1, 1'b0);
    pulse(16'h51, 16'h52, 16'h53, 16'h54, 16'd1, 1'b1, 1'b0);
    pulse(16'h61, 16'h62, 16'h63, 16'h64, 16'd2, 1'b0, 1'b0);
    pulse(16'h71, 16'h72, 16'h73, 16'h74, 16'd3, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4b_drop_cnt2", {16'd0, drop_cnt}, 2);
    pulse(16'h81, 16'h82, 16'h83, 16'h84, 16'd3, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4b_overflow", {31'd0, overflow}, 1);
    chk("t4b_drop_cnt", {16'd0, drop_cnt}, 1);
    wait_idle(60);
    chk("t4b_frame_cnt", {16'd0, frame_cnt}, exp_frames);
    clr_overflow = 1'b1;
    tick;
    clr_overflow = 1'b0;

    // 5: async reset mid-frame
    tready = 1'b1;
    pulse(16'hA1, 16'hA2, 16'hA3, 16'hA4, 16'd1, 1'b1, 1'b0);
    tick;
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_tvalid", {31'd0, tvalid}, 0);
    chk("t5_rst_tlast", {31'd0, tlast}, 0);
    chk("t5_rst_busy", {31'd0, busy}, 0);
    chk("t5_rst_cnt", {16'd0, frame_cnt}, 0);
    q1.delete();
    exp_frames = 0;
    #1 rst = 1'b0;
    tick;
    chk("t5_idle_after", {31'd0, tvalid}, 0);
    pulse(16'hB1, 16'hB2, 16'hB3, 16'hB4, 16'd3, 1'b1, 1'b0);
    wait_idle(40);
    chk("t5_frame_cnt", {16'd0, frame_cnt}, 1);

    // 6: single-beat frames, vec_valid every cycle
    tready2 = 1'b1;
    fork
      begin
        @(negedge clk);
        repeat (4) begin
          @(negedge clk);
          chk("t6_continuous", {31'd0, tvalid2}, 1);
        end
        @(negedge clk);
        chk("t6_end_idle", {31'd0, tvalid2}, 0);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          vec_valid2 = 1'b1;
          vec_data2  = 16'(11 + k);
          class_idx2 = 16'(k);
          q2.push_back('{16'(11 + k), 1'b1});
          tick;
        end
        vec_valid2 = 1'b0;
      end
    join
    tick;
    chk("t6_frame_cnt", {16'd0, frame_cnt2}, 4);
    chk("t6_q_empty", q2.size(), 0);
    chk("final_q_empty", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
